ifetch_align_buf: RTL and testbench
===================================

// Module: ifetch_align_buf
// PURPOSE
//  Parametrised instruction fetch/align buffer for the RV32IMC core, sitting between the
//  32-bit word imem port and comp_decoder/riscv. Fetches aligned words, queues halfwords,
//  and presents one whole instruction per handshake with its PC: a 16-bit compressed one,
//  or a 32-bit one at any halfword PC, including those spanning a word boundary.
//  Supports multiple outstanding fetches, redirect flush with in-flight discard, fault tagging.
// PARAMETERS
//  DEPTH        8    halfword FIFO entries; power of 2, >= 4
//  OUTSTANDING  2    max imem requests in flight, 1..4
//  RESET_PC     0    first fetch address after reset (bits [1:0] ignored for fetch)
// PORTS
//  clk             in   1   clock, single domain
//  resetb          in   1   asynchronous active-low reset
//  flush           in   1   redirect: discard buffer and in-flight data
//  flush_pc        in   32  new PC on flush; bit 0 ignored
//  imem_ready      out  1   request strobe; request accepted the cycle it is high
//  imem_addr       out  32  word-aligned request address, [1:0]=0
//  imem_valid      in   1   response strobe; responses return in request order, >=1 cycle later
//  imem_rresp      in   1   1=OK, 0=bus error for this response
//  imem_rdata      in   32  response word
//  ins_valid       out  1   instruction available
//  ins_ready       in   1   consumer accepts instruction
//  ins_data        out  32  {h1,h0} if 32-bit, {16'h0,h0} if compressed
//  ins_pc          out  32  PC of ins_data
//  ins_compressed  out  1   h0[1:0]!=2'b11
//  ins_fault       out  1   any consumed halfword came from an imem_rresp=0 response
// BEHAVIOUR
//  Reset: imem_ready=0, imem_addr=RESET_PC&~3, ins_valid=0, ins_data=0, ins_pc=RESET_PC,
//   ins_compressed=0, ins_fault=0; FIFO empty, pointers/count/inflight/discard=0;
//   drop_low=RESET_PC[1]. First request issues on the first clock after reset release.
//  FIFO: DEPTH x {fault,halfword[15:0]}; wr/rd pointers wrap mod DEPTH; count 0..DEPTH.
//  Request rule: imem_ready = !flush && inflight<OUTSTANDING &&
//   count + 2*(inflight+1) <= DEPTH. Guarantees no overflow. On request fetch_addr += 4
//   (wraps at 2^32).
//  Response (imem_valid, discard==0): push low then high half, both tagged fault=!imem_rresp;
//   if drop_low set, push high half only and clear drop_low. inflight decrements.
//  Response with discard>0: dropped entirely; discard and inflight decrement.
//  Output (combinational from FIFO head): h0=head, h1=head+1.
//   h0[1:0]!=2'b11: ins_valid = count>=1, pops 1, ins_pc += 2.
//   else: ins_valid = count>=2, pops 2, ins_pc += 4; ins_fault = fault(h0)|fault(h1).
//   ins_valid=0 drives ins_data=0, ins_compressed=0, ins_fault=0.
//  Pop on ins_valid&&ins_ready; push and pop in one cycle allowed; count updates by net.
//  Flush (highest priority, overrides push/pop/request same cycle): FIFO cleared,
//   ins_pc=flush_pc&~1, fetch_addr=flush_pc&~3, drop_low=flush_pc[1],
//   discard = inflight minus any response arriving that same cycle; request resumes next cycle.
//  Back-to-back flushes: discard accumulates correctly; never underflows.
//  Fault: instruction still delivered with ins_fault=1; the consumer raises the exception.
//   No auto-stop.
//  Reset mid-operation: all state returns to reset values immediately; late responses
//   after release are undefined. The memory side must also be reset.
// TESTING
//  1 Words 0x00000013 at 0,4,8, ins_ready=1 -> ins_pc 0,4,8; ins_data 0x00000013;
//    compressed=0.
//  2 word0=0x05134505, word1=0x00000000 -> pc0 data 0x00004505 comp=1; pc2 data 0x00000513
//    comp=0; next pc6.
//  3 Flush flush_pc=0x102 with 2 requests in flight -> both responses dropped; first ins_pc
//    0x102 from word 0x100 high half.
//  4 ins_ready=0 for 20 cycles -> count<=DEPTH, imem_ready low once full, then in-order
//    delivery, none lost.
//  5 imem_rresp=0 on word 0x8 -> instruction at pc 0x8 has ins_fault=1; pc 0x4 has
//    ins_fault=0. 32-bit instr at 0x6 spanning into 0x8 has ins_fault=1.
//  6 resetb low with 2 in flight -> all outputs at reset values same cycle; after release,
//    first imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_align_buf_if.sv
// Fetch/align buffer signal bundle: imem request/response, redirect, and instruction output.
// master = the fetch buffer itself, slave = the core/memory environment around it.
interface ifetch_align_buf_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        imem_rresp;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_compressed;
    logic        ins_fault;

    modport master (
        input  flush, flush_pc, imem_valid, imem_rresp, imem_rdata, ins_ready,
        output imem_ready, imem_addr, ins_valid, ins_data, ins_pc, ins_compressed, ins_fault
    );

    modport slave (
        output flush, flush_pc, imem_valid, imem_rresp, imem_rdata, ins_ready,
        input  imem_ready, imem_addr, ins_valid, ins_data, ins_pc, ins_compressed, ins_fault
    );
endinterface

// File: rtl/ifetch_align_buf.sv
// Instruction fetch/align buffer: aligned imem words in, whole RV32IMC instructions out.
// Latency: a response word is presentable the cycle after it returns; output is combinational from the FIFO head.
// Backpressure: ins_ready low holds the head; requests stop once in-flight data could overflow the FIFO.
module ifetch_align_buf #(
    parameter int          DEPTH       = 8,
    parameter int          OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic               clk,
    input  logic               resetb,
    ifetch_align_buf_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        fault;
        logic [15:0] hw;
    } ent_t;

    ent_t          fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    inflight;
    logic [2:0]    discard;
    logic [31:0]   fetch_addr;
    logic [31:0]   pc_q;
    logic          drop_low;
    logic          started;

    ent_t        h0;
    ent_t        h1;
    logic        is_comp;
    logic        req;
    logic        keep;
    logic        dropped;
    logic        pop;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;
    logic [15:0] need;

    assign h0      = fifo_mem[rd_ptr];
    assign h1      = fifo_mem[rd_ptr + PW'(1)];
    assign is_comp = (h0.hw[1:0] != 2'b11);

    // Reserve room for every in-flight word plus the one about to be requested.
    assign need    = 16'(count) + {12'd0, inflight, 1'b0} + 16'd2;
    assign req     = started && !bus.flush && (inflight < 3'(OUTSTANDING)) && (need <= 16'(DEPTH));
    assign keep    = bus.imem_valid && (discard == 3'd0);
    assign dropped = bus.imem_valid && (discard != 3'd0);
    assign push_n  = keep ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
    assign pop     = bus.ins_valid && bus.ins_ready;
    assign pop_n   = pop ? (is_comp ? 2'd1 : 2'd2) : 2'd0;

    assign bus.imem_ready     = req;
    assign bus.imem_addr      = fetch_addr;
    assign bus.ins_pc         = pc_q;
    assign bus.ins_valid      = is_comp ? (count >= CW'(1)) : (count >= CW'(2));
    assign bus.ins_data       = !bus.ins_valid ? 32'h0 :
                                is_comp ? {16'h0, h0.hw} : {h1.hw, h0.hw};
    assign bus.ins_compressed = bus.ins_valid && is_comp;
    assign bus.ins_fault      = bus.ins_valid && (h0.fault || (!is_comp && h1.fault));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inflight   <= '0;
            discard    <= '0;
            fetch_addr <= RESET_PC & ~32'd3;
            pc_q       <= RESET_PC;
            drop_low   <= RESET_PC[1];
            started    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (bus.flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                pc_q       <= bus.flush_pc & ~32'd1;
                fetch_addr <= bus.flush_pc & ~32'd3;
                drop_low   <= bus.flush_pc[1];
                // Everything still outstanding after this cycle belongs to the old stream.
                inflight   <= inflight - {2'b0, bus.imem_valid};
                discard    <= inflight - {2'b0, bus.imem_valid};
            end else begin
                wr_ptr   <= wr_ptr + PW'(push_n);
                rd_ptr   <= rd_ptr + PW'(pop_n);
                count    <= count + CW'(push_n) - CW'(pop_n);
                inflight <= inflight + {2'b0, req} - {2'b0, bus.imem_valid};
                if (dropped) discard    <= discard - 3'd1;
                if (keep)    drop_low   <= 1'b0;
                if (req)     fetch_addr <= fetch_addr + 32'd4;
                if (pop)     pc_q       <= pc_q + (is_comp ? 32'd2 : 32'd4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep && !bus.flush) begin
            if (drop_low) begin
                fifo_mem[wr_ptr] <= {!bus.imem_rresp, bus.imem_rdata[31:16]};
            end else begin
                fifo_mem[wr_ptr]          <= {!bus.imem_rresp, bus.imem_rdata[15:0]};
                fifo_mem[wr_ptr + PW'(1)] <= {!bus.imem_rresp, bus.imem_rdata[31:16]};
            end
        end
    end
endmodule

// File: tb/tb_ifetch_align_buf.sv
// Randomized bench for ifetch_align_buf: in-order memory model with random latency, and an
// instruction-stream reference that decodes straight from memory contents at the expected PC.
module tb_ifetch_align_buf;
    localparam int          DEPTH       = 8;
    localparam int          OUTSTANDING = 2;
    localparam logic [31:0] RESET_PC    = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        comp;
        logic        fault;
    } rec_t;

    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    ifetch_align_buf_if bus ();

    ifetch_align_buf #(
        .DEPTH      (DEPTH),
        .OUTSTANDING(OUTSTANDING),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] wmem [int unsigned];
    bit          fmem [int unsigned];
    bit          rand_fault = 1'b0;
    int          rdy_pct = 70;
    int          vld_pct = 70;
    int          max_lat = 3;
    bit          hold_resp = 1'b0;
    logic [31:0] mq_addr [$];
    int          mq_due [$];
    int          cyc = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_fetch;
    rec_t        log_q [$];
    int          n_req = 0;
    int          n_ins = 0;
    logic [31:0] last_req_addr = 32'h0;
    logic        last_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] k;
        logic [31:0] x;
        k = a & ~32'd3;
        if (wmem.exists(k)) return wmem[k];
        x = k * 32'h9E3779B1;
        x = x ^ (x >> 15);
        x = x * 32'h85EBCA6B;
        return x ^ (x >> 13);
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic bit fault_at(input logic [31:0] a);
        logic [31:0] k;
        logic [31:0] x;
        k = a & ~32'd3;
        if (fmem.exists(k)) return fmem[k];
        x = (k ^ 32'h5BD1E995) * 32'h2545F491;
        return rand_fault && (x[31:28] == 4'h0);
    endfunction

    // One clock: drive inputs at the falling edge, sample after settling, then update the model.
    task automatic step(input bit do_flush, input logic [31:0] fpc);
        int          out_before;
        logic [31:0] a;
        logic [31:0] edata;
        logic [15:0] h0;
        logic        ecomp;
        logic        efault;
        rec_t        r;
        @(negedge clk);
        out_before = mq_addr.size();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.imem_rresp = 1'b1;
        if (!hold_resp && out_before > 0 && cyc >= mq_due[0] &&
            int'($urandom_range(99)) < vld_pct) begin
            a = mq_addr.pop_front();
            void'(mq_due.pop_front());
            bus.imem_valid = 1'b1;
            bus.imem_rdata = word_at(a);
            bus.imem_rresp = !fault_at(a);
        end
        bus.flush     = do_flush;
        bus.flush_pc  = fpc;
        bus.ins_ready = int'($urandom_range(99)) < rdy_pct;
        #1;
        last_ready = bus.imem_ready;
        if (do_flush) chk("req_in_flush", bus.imem_ready, 0);
        if (bus.imem_ready) begin
            chk("outstanding", out_before < OUTSTANDING, 1);
            chk("fetch_addr", bus.imem_addr, exp_fetch);
            mq_addr.push_back(bus.imem_addr);
            mq_due.push_back(cyc + int'($urandom_range(max_lat, 1)));
            last_req_addr = bus.imem_addr;
            n_req++;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (!bus.ins_valid)
            chk("idle_zero", bus.ins_data | {30'd0, bus.ins_compressed, bus.ins_fault}, 0);
        if (do_flush) begin
            model_pc  = fpc & ~32'd1;
            exp_fetch = fpc & ~32'd3;
        end else if (bus.ins_valid && bus.ins_ready) begin
            h0 = hw_at(model_pc);
            if (h0[1:0] != 2'b11) begin
                edata  = {16'h0, h0};
                ecomp  = 1'b1;
                efault = fault_at(model_pc);
            end else begin
                edata  = {hw_at(model_pc + 32'd2), h0};
                ecomp  = 1'b0;
                efault = fault_at(model_pc) | fault_at(model_pc + 32'd2);
            end
            chk("ins_pc", bus.ins_pc, model_pc);
            chk("ins_data", bus.ins_data, edata);
            chk("ins_comp", bus.ins_compressed, ecomp);
            chk("ins_fault", bus.ins_fault, efault);
            r.pc    = bus.ins_pc;
            r.data  = bus.ins_data;
            r.comp  = bus.ins_compressed;
            r.fault = bus.ins_fault;
            log_q.push_back(r);
            n_ins++;
            model_pc = model_pc + (ecomp ? 32'd2 : 32'd4);
        end
        cyc++;
    endtask

    task automatic redirect(input logic [31:0] pc);
        step(1'b1, pc);
        log_q.delete();
    endtask

    task automatic run_n(input int n, input int budget);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            step(1'b0, 32'h0);
            k++;
        end
        chk("progress", 32'(log_q.size()), 32'(n));
    endtask

    task automatic wait_inflight(input string tag);
        int k;
        k = 0;
        while (mq_addr.size() < 2 && k < 12) begin
            step(1'b0, 32'h0);
            k++;
        end
        chk(tag, 32'(mq_addr.size()), 32'd2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        resetb         = 1'b0;
        bus.flush      = 1'b0;
        bus.imem_valid = 1'b0;
        bus.ins_ready  = 1'b0;
        #1;
        chk("rst_imem_ready", bus.imem_ready, 0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC & ~32'd3);
        chk("rst_ins_valid", bus.ins_valid, 0);
        chk("rst_ins_data", bus.ins_data, 0);
        chk("rst_ins_pc", bus.ins_pc, RESET_PC);
        chk("rst_ins_comp", bus.ins_compressed, 0);
        chk("rst_ins_fault", bus.ins_fault, 0);
        mq_addr.delete();
        mq_due.delete();
        log_q.delete();
        model_pc  = RESET_PC;
        exp_fetch = RESET_PC & ~32'd3;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
    endtask

    function automatic void set_mem(input logic [31:0] w0, input logic [31:0] w4,
                                    input logic [31:0] w8, input bit f8);
        wmem.delete();
        fmem.delete();
        rand_fault = 1'b0;
        wmem[0] = w0;
        wmem[4] = w4;
        wmem[8] = w8;
        if (f8) fmem[8] = 1'b1;
    endfunction

    initial begin
        int base;
        int k;
        resetb         = 1'b0;
        bus.flush      = 1'b0;
        bus.flush_pc   = 32'h0;
        bus.imem_valid = 1'b0;
        bus.imem_rresp = 1'b1;
        bus.imem_rdata = 32'h0;
        bus.ins_ready  = 1'b0;
        do_reset();

        // Plain 32-bit instructions at consecutive words.
        set_mem(32'h00000013, 32'h00000013, 32'h00000013, 1'b0);
        redirect(32'h0);
        run_n(3, 60);
        for (int i = 0; i < 3; i++) begin
            chk("t1_pc", log_q[i].pc, 32'(4 * i));
            chk("t1_data", log_q[i].data, 32'h00000013);
            chk("t1_comp", log_q[i].comp, 0);
        end

        // Compressed followed by a 32-bit instruction spanning a word boundary.
        set_mem(32'h05134505, 32'h00000000, 32'h00000013, 1'b0);
        redirect(32'h0);
        run_n(3, 60);
        chk("t2_data0", log_q[0].data, 32'h00004505);
        chk("t2_comp0", log_q[0].comp, 1);
        chk("t2_pc1", log_q[1].pc, 32'h2);
        chk("t2_data1", log_q[1].data, 32'h00000513);
        chk("t2_comp1", log_q[1].comp, 0);
        chk("t2_pc2", log_q[2].pc, 32'h6);

        // Redirect to an odd-halfword PC while two fetches are outstanding.
        set_mem(32'h00000013, 32'h00000013, 32'h00000013, 1'b0);
        wmem[32'h100] = 32'h80821234;
        wmem[32'h104] = 32'h00000013;
        do_reset();
        hold_resp = 1'b1;
        wait_inflight("t3_inflight");
        hold_resp = 1'b0;
        redirect(32'h102);
        run_n(2, 60);
        chk("t3_pc0", log_q[0].pc, 32'h102);
        chk("t3_data0", log_q[0].data, 32'h00008082);
        chk("t3_comp0", log_q[0].comp, 1);
        chk("t3_pc1", log_q[1].pc, 32'h104);

        // Consumer stall: buffer fills, requests stop, then everything drains in order.
        wmem.delete();
        fmem.delete();
        rdy_pct = 0;
        vld_pct = 100;
        max_lat = 1;
        redirect(32'h400);
        repeat (20) step(1'b0, 32'h0);
        chk("t4_stall_full", last_ready, 0);
        chk("t4_none_taken", 32'(log_q.size()), 0);
        rdy_pct = 100;
        run_n(12, 200);
        rdy_pct = 70;
        vld_pct = 70;
        max_lat = 3;

        // Bus error on word 0x8: 32-bit instruction at 0x6 spans into it.
        set_mem(32'h00000013, 32'h00130001, 32'h00000001, 1'b1);
        redirect(32'h0);
        run_n(4, 80);
        chk("t5b_pc4", log_q[1].pc, 32'h4);
        chk("t5b_fault4", log_q[1].fault, 0);
        chk("t5b_pc6", log_q[2].pc, 32'h6);
        chk("t5b_fault6", log_q[2].fault, 1);
        chk("t5b_faultA", log_q[3].fault, 1);
        set_mem(32'h00000013, 32'h00000013, 32'h00000013, 1'b1);
        redirect(32'h0);
        run_n(3, 80);
        chk("t5a_fault4", log_q[1].fault, 0);
        chk("t5a_pc8", log_q[2].pc, 32'h8);
        chk("t5a_fault8", log_q[2].fault, 1);

        // Reset with fetches outstanding; first fetch afterwards restarts at the reset PC.
        wmem.delete();
        fmem.delete();
        redirect(32'h200);
        hold_resp = 1'b1;
        wait_inflight("t6_inflight");
        do_reset();
        hold_resp = 1'b0;
        base = n_req;
        k = 0;
        while (n_req == base && k < 8) begin
            step(1'b0, 32'h0);
            k++;
        end
        chk("t6_first_addr", last_req_addr, RESET_PC & ~32'd3);
        run_n(4, 100);

        // Address-space wrap.
        redirect(32'hFFFF_FFFA);
        run_n(6, 150);
        chk("wrap_pc", log_q[5].pc < 32'h20, 1);

        // Random traffic, random bus errors, random redirects.
        rand_fault = 1'b1;
        base = n_ins;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                rdy_pct = int'($urandom_range(100, 20));
                vld_pct = int'($urandom_range(100, 20));
                max_lat = int'($urandom_range(4, 1));
            end
            if ($urandom_range(99) < 2) step(1'b1, $urandom());
            else step(1'b0, 32'h0);
        end
        chk("rand_progress", (n_ins - base) >= 300, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
